// File: rtl/npc_ifu.sv
// npc instruction fetch unit: owns the PC, issues one word fetch at a time and hands
// {inst, inst_pc} to execute. Optional ebreak halt is enabled by IFU_EBREAK_HALT_EN.
module npc_ifu #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = 'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              rsp_valid,
    input  logic [31:0]       rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              halt
);

    // state | meaning
    // IDLE  | no request; one bubble after reset or a redirect seen in REQ
    // REQ   | request presented at pc
    // WAIT  | request accepted, awaiting response (drop marks a stale word)
    // HOLD  | instruction presented to execute
    // HALT  | ebreak retired, fetch stopped until reset
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } state_t;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic              drop, drop_nxt;
    logic [31:0]       inst_q, inst_nxt;
    logic [ADDR_W-1:0] redirect_aligned;
    logic              is_ebreak;

    assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};

`ifdef IFU_EBREAK_HALT_EN
    assign is_ebreak = (inst_q == EBREAK);
`else
    assign is_ebreak = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            drop   <= 1'b0;
            inst_q <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            drop   <= drop_nxt;
            inst_q <= inst_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        drop_nxt  = drop;
        inst_nxt  = inst_q;
        case (state)
            S_IDLE: begin
                if (redirect_valid) pc_nxt = redirect_aligned;
                state_nxt = S_REQ;
            end
            S_REQ: begin
                // Address must not change while req_valid is high, so a redirect
                // that misses the handshake retires the request for one cycle.
                if (req_ready) begin
                    state_nxt = S_WAIT;
                    if (redirect_valid) begin
                        pc_nxt   = redirect_aligned;
                        drop_nxt = 1'b1;
                    end
                end else if (redirect_valid) begin
                    pc_nxt    = redirect_aligned;
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (redirect_valid) pc_nxt = redirect_aligned;
                if (rsp_valid) begin
                    if (drop || redirect_valid) begin
                        drop_nxt  = 1'b0;
                        state_nxt = S_REQ;
                    end else begin
                        inst_nxt  = rsp_data;
                        state_nxt = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_aligned;
                    state_nxt = S_REQ;
                end else if (inst_ready) begin
                    if (is_ebreak) begin
                        state_nxt = S_HALT;
                    end else begin
                        pc_nxt    = pc + ADDR_W'(4);
                        state_nxt = S_REQ;
                    end
                end
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign req_valid  = (state == S_REQ);
    assign req_addr   = pc;
    assign inst_valid = (state == S_HOLD);
    assign inst       = inst_q;
    assign inst_pc    = pc;
    assign halt       = (state == S_HALT);

endmodule
